// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the UART sender: pops one byte per frame onto TX_DATA/TX_SEND, paced by TX_STATUS.
// Latency: push at N, TX_SEND after N+1. The write side never stalls; pushes to a full FIFO are dropped and flag overflow.
module uart_tx_fifo #(
    parameter int ADDR_W       = 4,
    parameter int BUSY_TIMEOUT = 1023
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    input  logic              clr_err,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              tx_timeout,
    output logic              busy,
    input  logic              TX_STATUS,
    output logic              TX_SEND,
    output logic [7:0]        TX_DATA
);
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam int TMR_W = (BUSY_TIMEOUT < 2) ? 1 : $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    logic [7:0]        mem [2**ADDR_W];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_nxt;
    logic              push_ok;
    logic              pop;
    logic              drop;

    state_t            state;
    state_t            state_nxt;
    logic [TMR_W-1:0]  tmr;
    logic [TMR_W-1:0]  tmr_nxt;
    logic              tx_send_nxt;
    logic [7:0]        tx_data_nxt;
    logic              timeout_evt;

    // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
    assign push_ok = wr_en && (!full || pop);
    assign drop    = wr_en && full && !pop;
    assign busy    = (state != IDLE);

    always_comb begin
        count_nxt = count;
        if (push_ok && !pop) begin
            count_nxt = count + 1'b1;
        end else if (pop && !push_ok) begin
            count_nxt = count - 1'b1;
        end
    end

    always_ff @(posedge sysclk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_nxt;
            full  <= (count_nxt == DEPTH);
            empty <= (count_nxt == '0);
        end
    end

    always_comb begin
        state_nxt   = state;
        tmr_nxt     = tmr;
        tx_send_nxt = 1'b0;
        tx_data_nxt = TX_DATA;
        pop         = 1'b0;
        timeout_evt = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && TX_STATUS) begin
                    pop         = 1'b1;
                    tx_data_nxt = mem[rd_ptr];
                    tx_send_nxt = 1'b1;
                    tmr_nxt     = '0;
                    state_nxt   = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                tmr_nxt = tmr + TMR_W'(1);
                if (!TX_STATUS) begin
                    state_nxt = WAIT_DONE;
                end else if (tmr == TMR_W'(BUSY_TIMEOUT)) begin
                    // Sender never started the frame; the byte is abandoned.
                    timeout_evt = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            WAIT_DONE: begin
                if (TX_STATUS) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state      <= IDLE;
            tmr        <= '0;
            TX_SEND    <= 1'b0;
            TX_DATA    <= 8'h00;
            overflow   <= 1'b0;
            tx_timeout <= 1'b0;
        end else begin
            state   <= state_nxt;
            tmr     <= tmr_nxt;
            TX_SEND <= tx_send_nxt;
            TX_DATA <= tx_data_nxt;
            // Sticky flags: a new event outranks a clear in the same cycle.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (timeout_evt) begin
                tx_timeout <= 1'b1;
            end else if (clr_err) begin
                tx_timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a sender model drives TX_STATUS, a queue holds the bytes expected on the wire,
// and a negedge monitor checks every TX_SEND, TX_DATA and the occupancy flags against that queue.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
    localparam int ADDR_W       = 4;
    localparam int DEPTH        = 16;
    localparam int BUSY_TIMEOUT = 1023;

    logic              sysclk    = 1'b0;
    logic              reset     = 1'b1;
    logic              wr_en     = 1'b0;
    logic [7:0]        wr_data   = 8'h00;
    logic              clr_err   = 1'b0;
    logic              TX_STATUS = 1'b1;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              tx_timeout;
    logic              busy;
    logic              TX_SEND;
    logic [7:0]        TX_DATA;

    uart_tx_fifo #(.ADDR_W(ADDR_W), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .clr_err    (clr_err),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
        .tx_timeout (tx_timeout),
        .busy       (busy),
        .TX_STATUS  (TX_STATUS),
        .TX_SEND    (TX_SEND),
        .TX_DATA    (TX_DATA)
    );

    always #5 sysclk = ~sysclk;

    typedef enum int {NORMAL, STALL, DEAF} mode_t;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] sb[$];
    int         n_acc = 0;
    int         acc_base = 0;
    int         n_sent = 0;
    int         n_tx = 0;
    int         rst_gen = 0;
    mode_t      mode = NORMAL;
    int         fix_dly = -1;
    int         fix_len = 0;

    // monitor state
    logic       prev_send = 1'b0;
    logic       prev_status = 1'b1;
    logic [7:0] exp_data = 8'h00;
    int         seen_gen = 0;
    int         exp_cnt = 0;

    // sender model state
    int         snd_dly = 0;
    int         snd_len = 0;
    bit         snd_active = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic push(input logic [7:0] b, input bit acc);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en   = 1'b0;
        if (acc) begin
            sb.push_back(b);
            n_acc++;
        end
    endtask

    function automatic int stored();
        return n_acc - acc_base - n_sent;
    endfunction

    task automatic drain(input string name);
        int c = 0;
        while ((!empty || busy) && c < 5000) begin
            tick();
            c++;
        end
        check({name, "_drained"}, {31'd0, (!empty || busy)}, 0);
        check({name, "_scoreboard_empty"}, sb.size(), 0);
    endtask

    // Monitor: every TX_SEND must carry the oldest accepted byte; TX_DATA holds it until the next send.
    initial begin
        forever begin
            @(negedge sysclk);
            if (seen_gen != rst_gen) begin
                seen_gen  = rst_gen;
                sb.delete();
                acc_base  = n_acc;
                n_sent    = 0;
                exp_data  = 8'h00;
                prev_send = 1'b0;
            end
            if (!reset) begin
                if (TX_SEND) begin
                    n_tx++;
                    n_sent++;
                    check("tx_send_single_cycle", prev_send, 0);
                    check("tx_send_only_when_status_idle", prev_status, 1);
                    check("tx_send_has_expected_byte", {31'd0, sb.size() > 0}, 1);
                    if (sb.size() > 0) begin
                        exp_data = sb.pop_front();
                    end
                end
                check("tx_data", TX_DATA, exp_data);
                exp_cnt = n_acc - acc_base - n_sent;
                check("count", count, exp_cnt);
                check("full", full, exp_cnt == DEPTH);
                check("empty", empty, exp_cnt == 0);
            end
            prev_send   = TX_SEND;
            prev_status = TX_STATUS;
        end
    end

    // Sender model: goes busy a few cycles after TX_SEND, stays busy for a frame, then returns idle.
    initial begin
        forever begin
            @(posedge sysclk);
            #2;
            case (mode)
                STALL: begin
                    snd_active = 1'b0;
                    TX_STATUS  = 1'b0;
                end
                DEAF: begin
                    snd_active = 1'b0;
                    TX_STATUS  = 1'b1;
                end
                default: begin
                    if (TX_SEND) begin
                        snd_active = 1'b1;
                        snd_dly    = (fix_dly >= 0) ? fix_dly : int'($urandom_range(0, 3));
                        snd_len    = (fix_len > 0) ? fix_len : int'($urandom_range(1, 12));
                    end
                    if (!snd_active) begin
                        TX_STATUS = 1'b1;
                    end else if (snd_dly > 0) begin
                        snd_dly--;
                    end else if (snd_len > 0) begin
                        TX_STATUS = 1'b0;
                        snd_len--;
                    end else begin
                        TX_STATUS  = 1'b1;
                        snd_active = 1'b0;
                    end
                end
            endcase
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int peak;
        int ntx0;

        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        rst_gen++;
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_tx_send", TX_SEND, 0);
        check("rst_tx_data", TX_DATA, 8'h00);
        check("rst_overflow", overflow, 0);
        check("rst_tx_timeout", tx_timeout, 0);
        check("rst_busy", busy, 0);

        // T1: single byte, sender busy 5 cycles after the pulse for 100 cycles
        fix_dly = 5;
        fix_len = 100;
        push(8'hA5, 1'b1);
        check("t1_count_after_push", count, 1);
        check("t1_no_send_yet", TX_SEND, 0);
        tick();
        check("t1_send", TX_SEND, 1);
        check("t1_data", TX_DATA, 8'hA5);
        check("t1_count_after_pop", count, 0);
        check("t1_busy", busy, 1);
        cyc = 0;
        while (busy && cyc < 400) begin
            tick();
            cyc++;
        end
        check("t1_busy_falls", busy, 0);
        check("t1_status_at_busy_fall", TX_STATUS, 1);
        check("t1_frame_held", {31'd0, cyc >= 100}, 1);

        // T2: 16 back-to-back pushes with a slow sender
        fix_dly = 2;
        fix_len = 30;
        peak = 0;
        for (int i = 0; i < 16; i++) begin
            push(8'(i), 1'b1);
            if (int'(count) > peak) peak = int'(count);
            check("t2_not_full", full, 0);
        end
        check("t2_peak_count", peak, 15);
        drain("t2");

        // T3: fill with sender stalled, then overflow
        fix_dly = -1;
        fix_len = 0;
        mode = STALL;
        repeat (2) tick();
        for (int i = 0; i < 16; i++) begin
            push(8'($urandom_range(0, 254)), 1'b1);
            check("t3_fill_count", count, i + 1);
        end
        check("t3_full", full, 1);
        check("t3_no_overflow_yet", overflow, 0);
        push(8'hFF, 1'b0);
        check("t3_overflow_set", overflow, 1);
        check("t3_count_held", count, 16);
        clr_err = 1'b1;
        push(8'hFE, 1'b0);
        clr_err = 1'b0;
        check("t3_set_beats_clear", overflow, 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("t3_overflow_cleared", overflow, 0);

        // T4: full FIFO, pop and push on the same edge
        mode = NORMAL;
        push(8'h5C, 1'b1);
        check("t4_count_stays_full", count, 16);
        check("t4_full", full, 1);
        check("t4_no_overflow", overflow, 0);
        check("t4_popped", TX_SEND, 1);
        drain("t4");

        // T5: sender never goes busy
        mode = DEAF;
        push(8'h3C, 1'b1);
        push(8'hC3, 1'b1);
        check("t5_send", TX_SEND, 1);
        repeat (1023) tick();
        check("t5_no_timeout_before", tx_timeout, 0);
        check("t5_still_waiting", busy, 1);
        tick();
        check("t5_timeout_set", tx_timeout, 1);
        check("t5_back_to_idle", busy, 0);
        mode = NORMAL;
        tick();
        check("t5_next_send", TX_SEND, 1);
        check("t5_next_data", TX_DATA, 8'hC3);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("t5_timeout_cleared", tx_timeout, 0);
        drain("t5");

        // Randomized traffic against a randomly paced sender
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 2) != 0 && stored() <= 14) begin
                push(8'($urandom), 1'b1);
            end else begin
                tick();
            end
        end
        drain("rand");
        check("rand_no_overflow", overflow, 0);
        check("rand_no_timeout", tx_timeout, 0);

        // T6: reset while a frame is in flight with 3 bytes queued
        fix_dly = 1;
        fix_len = 200;
        for (int i = 0; i < 4; i++) begin
            push(8'(8'h80 + i), 1'b1);
        end
        repeat (10) tick();
        check("t6_queued", count, 3);
        check("t6_in_frame", busy, 1);
        check("t6_sender_busy", TX_STATUS, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rst_gen++;
        check("t6_tx_send", TX_SEND, 0);
        check("t6_count", count, 0);
        check("t6_busy", busy, 0);
        check("t6_empty", empty, 1);
        check("t6_tx_data", TX_DATA, 8'h00);
        ntx0 = n_tx;
        repeat (300) tick();
        check("t6_no_further_send", n_tx, ntx0);
        check("t6_count_after", count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
